// File: rtl/astro_game_ctrl_if.sv
// Event and status bundle between the sprite/VGA datapath and the game-flow sequencer.
// The datapath side (master) raises the tick/shot/hit events; the sequencer (slave) returns game status.
interface astro_game_ctrl_if;
    logic       tick_en;
    logic       shot_fired;
    logic       shot_done;
    logic       hit;
    logic [1:0] state;
    logic       active_player;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] shots_left;
    logic [3:0] round;
    logic       game_en;
    logic       shot_armed;
    logic       target_reset;
    logic [1:0] winner;

    modport master (
        output tick_en, shot_fired, shot_done, hit,
        input  state, active_player, p1_score, p2_score, shots_left, round,
               game_en, shot_armed, target_reset, winner
    );

    modport slave (
        input  tick_en, shot_fired, shot_done, hit,
        output state, active_player, p1_score, p2_score, shots_left, round,
               game_en, shot_armed, target_reset, winner
    );
endinterface

// File: rtl/astro_game_ctrl.sv
// Game-flow sequencer for the two-player barrier shooter: turns, shots, scores, rounds and pauses.
//
//  state   | meaning
//  QI      | idle, waiting for a rising edge of the start switch
//  QGAME_1 | player 1 turn (paused while the pause counter is non-zero)
//  QGAME_2 | player 2 turn (paused while the pause counter is non-zero)
//  QDONE   | game over, results held until start is released
module astro_game_ctrl #(
    parameter int WIN_SCORE      = 10,
    parameter int SHOTS_PER_TURN = 5,
    parameter int MAX_ROUNDS     = 3,
    parameter int PAUSE_TICKS    = 32
) (
    input  logic              board_clk,
    input  logic              reset,
    input  logic              start,
    astro_game_ctrl_if.slave  gif
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [3:0] WIN_C    = 4'(WIN_SCORE);
    localparam logic [3:0] SHOTS_C  = 4'(SHOTS_PER_TURN);
    localparam logic [3:0] ROUNDS_C = 4'(MAX_ROUNDS);
    localparam logic [7:0] PAUSE_C  = 8'(PAUSE_TICKS);

    logic       start_meta_q, start_sync_q, start_prev_q;
    logic       start_rise;

    state_t     state_q, state_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic [3:0] shots_q, shots_d;
    logic [3:0] round_q, round_d;
    logic [1:0] winner_q, winner_d;
    logic       in_flight_q, in_flight_d;
    logic [7:0] pause_q, pause_d;
    logic       target_reset_q, target_reset_d;

    logic       in_game;
    logic       game_en;
    logic       shot_armed;
    logic [3:0] p1_inc, p2_inc;

    // Two-flop synchronizer for the start switch plus a delayed copy for edge detection.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
        end
    end

    assign start_rise = start_sync_q & ~start_prev_q;

    assign in_game    = (state_q == QGAME_1) || (state_q == QGAME_2);
    assign game_en    = in_game && (pause_q == 8'd0);
    assign shot_armed = game_en && !in_flight_q && (shots_q != 4'd0);

    // Scores never pass WIN_SCORE, so a 4-bit score cannot wrap.
    assign p1_inc = (p1_score_q >= WIN_C) ? WIN_C : p1_score_q + 4'd1;
    assign p2_inc = (p2_score_q >= WIN_C) ? WIN_C : p2_score_q + 4'd1;

    // Game state, scores, shot bookkeeping and pause counter registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q        <= QI;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            shots_q        <= 4'd0;
            round_q        <= 4'd0;
            winner_q       <= 2'b00;
            in_flight_q    <= 1'b0;
            pause_q        <= 8'd0;
            target_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            shots_q        <= shots_d;
            round_q        <= round_d;
            winner_q       <= winner_d;
            in_flight_q    <= in_flight_d;
            pause_q        <= pause_d;
            target_reset_q <= target_reset_d;
        end
    end

    // Next-state logic; within a turn a hit outranks shot_done, which outranks a new shot.
    always_comb begin
        state_d        = state_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        shots_d        = shots_q;
        round_d        = round_q;
        winner_d       = winner_q;
        in_flight_d    = in_flight_q;
        pause_d        = pause_q;
        target_reset_d = 1'b0;

        if ((pause_q != 8'd0) && gif.tick_en) begin
            pause_d = pause_q - 8'd1;
        end

        case (state_q)
            QI: begin
                if (start_rise) begin
                    state_d        = QGAME_1;
                    p1_score_d     = 4'd0;
                    p2_score_d     = 4'd0;
                    round_d        = 4'd1;
                    shots_d        = SHOTS_C;
                    winner_d       = 2'b00;
                    in_flight_d    = 1'b0;
                    pause_d        = 8'd0;
                    target_reset_d = 1'b1;
                end
            end
            QGAME_1, QGAME_2: begin
                if (game_en) begin
                    if (gif.hit && in_flight_q) begin
                        in_flight_d    = 1'b0;
                        target_reset_d = 1'b1;
                        if (state_q == QGAME_1) begin
                            p1_score_d = p1_inc;
                            if (p1_inc == WIN_C) begin
                                state_d  = QDONE;
                                winner_d = 2'b01;
                            end
                        end else begin
                            p2_score_d = p2_inc;
                            if (p2_inc == WIN_C) begin
                                state_d  = QDONE;
                                winner_d = 2'b10;
                            end
                        end
                    end else if (gif.shot_done && in_flight_q) begin
                        in_flight_d = 1'b0;
                    end else if (gif.shot_fired && shot_armed) begin
                        in_flight_d = 1'b1;
                        shots_d     = shots_q - 4'd1;
                    end else if ((shots_q == 4'd0) && !in_flight_q) begin
                        if ((state_q == QGAME_2) && (round_q == ROUNDS_C)) begin
                            state_d = QDONE;
                            if (p1_score_q > p2_score_q) begin
                                winner_d = 2'b01;
                            end else if (p2_score_q > p1_score_q) begin
                                winner_d = 2'b10;
                            end else begin
                                winner_d = 2'b11;
                            end
                        end else begin
                            if (state_q == QGAME_1) begin
                                state_d = QGAME_2;
                            end else begin
                                state_d = QGAME_1;
                                round_d = round_q + 4'd1;
                            end
                            shots_d        = SHOTS_C;
                            target_reset_d = 1'b1;
                            pause_d        = PAUSE_C;
                        end
                    end
                end
            end
            QDONE: begin
                if (!start_sync_q) begin
                    state_d = QI;
                end
            end
            default: state_d = QI;
        endcase
    end

    assign gif.state         = state_q;
    assign gif.active_player = (state_q == QGAME_2);
    assign gif.p1_score      = p1_score_q;
    assign gif.p2_score      = p2_score_q;
    assign gif.shots_left    = shots_q;
    assign gif.round         = round_q;
    assign gif.game_en       = game_en;
    assign gif.shot_armed    = shot_armed;
    assign gif.target_reset  = target_reset_q;
    assign gif.winner        = winner_q;

endmodule
